// File: rtl/inst_queue_if.sv
// Handshake bundle between instruction fetch, the instruction queue and the decode stage.
// The master side is the fetch/decode pair. The slave side is the queue.
interface inst_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         inst_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         inst_out;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;

  modport master (
    output flush, in_valid, inst_in, out_ready,
    input  in_ready, out_valid, inst_out, count, full, empty
  );

  modport slave (
    input  flush, in_valid, inst_in, out_ready,
    output in_ready, out_valid, inst_out, count, full, empty
  );
endinterface

// File: rtl/inst_queue.sv
// First-word-fall-through instruction queue with a flush input.
// When the queue is empty, inst_out presents a NOP word.
module inst_queue #(
  parameter int          WIDTH    = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst_n,
  inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_INST);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Pointers carry one extra wrap bit, so full and empty can be told apart without a separate counter.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = q.in_valid && !full && !q.flush;
  assign pop   = !empty && q.out_ready && !q.flush;

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.full      = full;
  assign q.empty     = empty;
  assign q.count     = wr_ptr - rd_ptr;
  assign q.inst_out  = empty ? NOP_W : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage has no reset. The empty mux hides stale entries until they are written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= q.inst_in;
  end
endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed checking of inst_queue against a queue-based reference model.
module tb_inst_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];

  inst_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) qif ();

  inst_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue holds the words that have been accepted and not yet taken.
  always @(posedge clk or negedge rst_n) begin
    int sz;
    logic do_pop;
    logic do_push;
    if (!rst_n) exp_q.delete();
    else if (qif.flush) exp_q.delete();
    else begin
      sz      = exp_q.size();
      do_pop  = (sz > 0) && qif.out_ready;
      do_push = qif.in_valid && (sz < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(qif.inst_in);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    qif.in_valid  = v;
    qif.inst_in   = d;
    qif.out_ready = r;
    qif.flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},     32'(qif.count), 32'd0);
    chk({tag, "_empty"},     32'(qif.empty), 32'd1);
    chk({tag, "_full"},      32'(qif.full), 32'd0);
    chk({tag, "_out_valid"}, 32'(qif.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(qif.in_ready), 32'd1);
    chk({tag, "_inst_out"},  qif.inst_out, NOP);
  endtask

  initial begin
    logic [31:0] held;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    qif.in_valid  = 1'b0;
    qif.inst_in   = '0;
    qif.out_ready = 1'b0;
    qif.flush     = 1'b0;
    #1;
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    fork
      begin : stimulus
        // Three pushes while the consumer is stalled.
        cyc(1, 32'h11, 0, 0);
        chk("fwft_head", qif.inst_out, 32'h11);
        chk("fwft_valid", 32'(qif.out_valid), 32'd1);
        cyc(1, 32'h22, 0, 0);
        cyc(1, 32'h33, 0, 0);
        chk("three_count", 32'(qif.count), 32'd3);
        chk("three_head", qif.inst_out, 32'h11);

        // Fill to full. A fifth offer is refused even while a pop happens.
        cyc(0, 32'h0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 32'(i), 0, 0);
        chk("full_flag", 32'(qif.full), 32'd1);
        chk("full_in_ready", 32'(qif.in_ready), 32'd0);
        cyc(1, 32'h99, 1, 0);
        chk("pop_at_full_count", 32'(qif.count), 32'd3);
        chk("pop_at_full_head", qif.inst_out, 32'd2);

        // Continuous streaming through an empty queue wraps the pointers twice.
        cyc(0, 32'h0, 0, 1);
        for (int i = 0; i < 10; i++) begin
          cyc(1, 32'h100 + 32'(i), 1, 0);
          chk("stream_count_le1", 32'(qif.count <= 1), 32'd1);
        end
        cyc(0, 32'h0, 1, 0);

        // A flush with an offered word drops both the queue contents and the offered word.
        for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i), 0, 0);
        cyc(1, 32'hAA, 0, 1);
        chk("flush_count", 32'(qif.count), 32'd0);
        chk("flush_empty", 32'(qif.empty), 32'd1);
        chk("flush_nop", qif.inst_out, NOP);
        cyc(0, 32'h0, 1, 0);
        chk("flush_no_aa", qif.inst_out, NOP);

        // An asynchronous reset pulse between clock edges.
        cyc(1, 32'h301, 0, 0);
        cyc(1, 32'h302, 0, 0);
        qif.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 32'h55, 0, 0);
        cyc(0, 32'h0, 0, 0);
        chk("post_rst_head", qif.inst_out, 32'h55);

        // A stall with a single entry queued.
        held = qif.inst_out;
        for (int i = 0; i < 5; i++) begin
          cyc(0, 32'h0, 0, 0);
          chk("stall_hold", qif.inst_out, held);
          chk("stall_count", 32'(qif.count), 32'd1);
        end

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++)
          cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 40) == 0));
        cyc(0, 32'h0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 32'h0, 1, 0);
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n) begin
            chk("mon_count", 32'(qif.count), 32'(exp_q.size()));
            chk("mon_empty", 32'(qif.empty), 32'(exp_q.size() == 0));
            chk("mon_full", 32'(qif.full), 32'(exp_q.size() == DEPTH));
            chk("mon_in_ready", 32'(qif.in_ready), 32'(exp_q.size() != DEPTH));
            chk("mon_out_valid", 32'(qif.out_valid), 32'(exp_q.size() != 0));
            if (qif.out_valid && exp_q.size() != 0) chk("mon_head", qif.inst_out, exp_q[0]);
            else chk("mon_nop", qif.inst_out, NOP);
          end
        end
      end
    join_any

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001: Parameter WIDTH, default 32, instruction word width in bits (>=8).
REQ-002: Parameter DEPTH, default 4, number of queue entries; power of two, >=2.
REQ-003: Parameter NOP_INST, default 32'h0000_0013, word presented on inst_out when the queue is empty (truncated/zero-extended to WIDTH).
REQ-004: clk  input  1  central clock; all state updates on posedge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: flush  input  1  synchronous discard of all queued instructions.
REQ-007: in_valid  input  1  producer offers inst_in this cycle.
REQ-008: in_ready  output  1  queue accepts a word this cycle.
REQ-009: inst_in  input  WIDTH  instruction word from fetch.
REQ-010: out_valid  output  1  inst_out holds a real queued instruction.
REQ-011: out_ready  input  1  consumer takes inst_out this cycle.
REQ-012: inst_out  output  WIDTH  head-of-queue instruction, or NOP_INST when empty.
REQ-013: count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-014: full  output  1  count == DEPTH.
REQ-015: empty  output  1  count == 0.

Function
REQ-016: Push occurs on a posedge when in_valid && in_ready && !flush; the word is written at the write pointer, and the write pointer advances by 1 modulo DEPTH.
REQ-017: Pop occurs on a posedge when out_valid && out_ready && !flush; the read pointer advances by 1 modulo DEPTH.
REQ-018: in_ready SHALL equal !full, combinationally; no push is accepted when full, even if a pop occurs in the same cycle.
REQ-019: out_valid SHALL equal !empty, combinationally.
REQ-020: inst_out SHALL be storage[read pointer] when !empty, else NOP_INST (first-word-fall-through; no extra output register).
REQ-021: A pushed word SHALL become visible on inst_out no earlier than the cycle after the push edge; there is no input-to-output bypass.
REQ-022: Read and write pointers SHALL carry one extra wrap bit; full = (ptrs equal except MSB), empty = (ptrs fully equal); count = wr_ptr - rd_ptr, computed modulo 2*DEPTH.
REQ-023: On a simultaneous push and pop with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-024: On a push and pop in the same cycle with count == 0, the pop is not possible (out_valid = 0); only the push takes effect, and count becomes 1.
REQ-025: Entries SHALL be delivered in strict push order across pointer wrap-around.
REQ-026: When flush = 1 at a posedge, both pointers SHALL return to 0 and count to 0. Any push or pop offered in that cycle SHALL be ignored. From the next cycle, inst_out SHALL be NOP_INST and out_valid SHALL be 0.
REQ-027: in_ready SHALL remain !full during a flush cycle. Words offered with flush = 1 are dropped; the producer is responsible for not treating them as accepted.
REQ-028: inst_out SHALL hold its value while out_ready = 0 and no flush occurs (stall behaviour).
REQ-029: Storage contents SHALL change only on accepted pushes.

Reset
REQ-030: While rst_n = 0, pointers SHALL be 0, count 0, empty 1, full 0, out_valid 0, in_ready 1, inst_out NOP_INST, regardless of clk.
REQ-031: Storage entries are not reset; their contents SHALL never be observable on inst_out until written after reset.
REQ-032: Assertion of rst_n mid-operation SHALL immediately discard all entries. After rst_n deasserts, the first accepted push SHALL be the first word output.

Verification
REQ-033: Reset, then push 0x11,0x22,0x33 on consecutive cycles with out_ready=0 -> count=3, inst_out=0x11 from the cycle after the first push, out_valid=1.
REQ-034: DEPTH=4: push 4 words -> full=1, in_ready=0. A fifth offer while out_ready=1 is not accepted; after the pop, count=3 and inst_out shows word 2.
REQ-035: Stream 10 words with in_valid=out_ready=1 continuously -> outputs are in order across two pointer wraps, and count never exceeds 1.
REQ-036: With 3 entries queued, assert flush together with in_valid (0xAA) -> next cycle count=0, empty=1, inst_out=0x00000013, and 0xAA is never output.
REQ-037: With 2 entries queued, pulse rst_n low between clock edges -> outputs take reset values immediately. After release, push 0x55 -> 0x55 is the next inst_out.
REQ-038: Hold out_ready=0 for 5 cycles with 1 entry queued -> inst_out is stable and count=1 throughout.
